alu_issue: RTL
==============

Name: alu_issue

Overview:
- Issue stage that feeds the ALU. It decodes a MIPS instruction word plus register-file read data into the ALU's src1/src2/ctrl operand triple and a destination register.
- Holds each decoded op in a registered output slot and a one-entry skid buffer, with valid/ready handshakes on both sides.
- Sits between the register-file read stage and the ALU/EX stage of the multi-cycle CPU datapath.

Parameters:
- CNT_W, 16, width of the saturating issued-op counter.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all held ops (branch redirect)
- in_valid_i  in  1  upstream offers instr_i/rs_data_i/rt_data_i
- in_ready_o  out  1  stage can accept this cycle
- instr_i  in  32  MIPS instruction word
- rs_data_i  in  32  register-file value of rs
- rt_data_i  in  32  register-file value of rt
- out_valid_o  out  1  src1_o/src2_o/ctrl_o/rd_addr_o/illegal_o are valid
- out_ready_i  in  1  ALU stage consumes this cycle
- src1_o  out  32  ALU operand 1
- src2_o  out  32  ALU operand 2
- ctrl_o  out  4  ALU control code
- rd_addr_o  out  5  writeback register (0 means no write)
- illegal_o  out  1  op was an undecodable instruction
- issue_cnt_o  out  CNT_W  count of completed output handshakes, saturating

Behaviour:
- ALU control codes: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7. Codes 8-15 are never emitted.
- Decode of R-type (opcode 0x00) by funct:
  - 0x24 -> AND; 0x25 -> OR; 0x27 -> NOR; 0x21 -> ADDU; 0x23 -> SUBU; 0x2A -> SLT.
  - src1=rs_data, src2=rt_data, rd=instr[15:11].
- Decode of I-type by opcode:
  - 0x09 ADDIU -> ADDU, src2=sign-extended imm16.
  - 0x0A SLTI -> SLT, src2=sign-extended imm16.
  - 0x0C ANDI -> AND, src2=zero-extended imm16.
  - 0x0D ORI -> OR, src2=zero-extended imm16.
  - For all four: src1=rs_data, rd=instr[20:16].
  - 0x04 BEQ -> EQUAL, src1=rs_data, src2=rt_data, rd=0.
- Any other opcode/funct: ctrl=ADDU, src1=src2=0, rd=0, illegal=1. The op still flows through the pipeline; illegal is never dropped silently.
- Decoded R-type with rd field 0 passes through unchanged; no special case.
- Handshake:
  - A transfer occurs on any cycle where valid&&ready on that side.
  - out_* must hold stable while out_valid_o=1 and out_ready_i=0.
- Storage is an output register (OR) plus a skid register (SK).
  - in_ready_o = !SK.valid, driven directly from a flop with no combinational path from out_ready_i.
  - Accepted op goes to OR if OR is empty or OR is draining this cycle; otherwise it goes to SK.
  - When OR drains and SK is full, SK moves to OR in the same cycle.
- Latency: 1 cycle from input handshake to out_valid_o when OR is empty.
- Throughput: 1 op/cycle sustained while out_ready_i=1.
- flush_i=1:
  - Next cycle OR.valid=0 and SK.valid=0.
  - An input handshake in the same cycle is accepted and dropped.
  - An output handshake in the same cycle still counts.
- issue_cnt_o increments on each output handshake, saturates at 2^CNT_W-1, and is not cleared by flush.
- Reset (rst_i=1 at an edge), including mid-transfer:
  - out_valid_o=0, in_ready_o=1, issue_cnt_o=0.
  - src1_o=0, src2_o=0, ctrl_o=0, rd_addr_o=0, illegal_o=0.
  - Reset overrides flush and all handshakes.

Decomposition:
- Package alu_pkg holds:
  - ALU control localparams (AND..EQUAL).
  - Opcode and funct constants.
  - The 4-bit ctrl width.
  - Shared with the ALU and top level.
- One combinational sub-module, alu_decode: instr/rs/rt in; src1/src2/ctrl/rd/illegal out.
- alu_issue contains only the OR/SK registers, handshake logic and counter.

Test Plan:
- Reset, then ADDU R-type (instr 0x00221821), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, src1=5, src2=7, ctrl=4, rd=3, illegal=0; issue_cnt=1 after handshake.
- ADDIU imm 0xFFFF, rs=10 -> src2=0xFFFFFFFF, ctrl=4. ANDI imm 0xFFFF -> src2=0x0000FFFF, ctrl=0. BEQ -> ctrl=7, rd=0.
- Back-to-back 3 ops, out_ready held 0 for 2 cycles -> in_ready drops to 0 after the 2nd accept; outputs hold op1 stable; release gives op1, op2 in order with none lost or duplicated.
- Random valid/ready stress, 1000 ops -> output sequence equals input sequence and issue_cnt equals handshake count.
- Flush with OR and SK full plus a concurrent input -> next cycle out_valid=0 and in_ready=1; dropped input never appears.
- Opcode 0x3F -> illegal=1, ctrl=4, src1=src2=0. Assert rst_i while stalled -> all outputs reach reset values the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, MIPS opcode/funct values and the
// decoded-op record carried through the issue stage.
package alu_pkg;

   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] ALU_AND   = 4'd0;
   localparam logic [CTRL_W-1:0] ALU_OR    = 4'd1;
   localparam logic [CTRL_W-1:0] ALU_NAND  = 4'd2;
   localparam logic [CTRL_W-1:0] ALU_NOR   = 4'd3;
   localparam logic [CTRL_W-1:0] ALU_ADDU  = 4'd4;
   localparam logic [CTRL_W-1:0] ALU_SUBU  = 4'd5;
   localparam logic [CTRL_W-1:0] ALU_SLT   = 4'd6;
   localparam logic [CTRL_W-1:0] ALU_EQUAL = 4'd7;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      logic [31:0]       src1;
      logic [31:0]       src2;
      logic [CTRL_W-1:0] ctrl;
      logic [4:0]        rd;
      logic              illegal;
   } issue_op_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] zext16(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode into the ALU operand triple and writeback register.
// Anything not recognised becomes an ADDU of zeros flagged illegal.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0]       instr_i,
   input  logic [31:0]       rs_data_i,
   input  logic [31:0]       rt_data_i,
   output logic [31:0]       src1_o,
   output logic [31:0]       src2_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [4:0]        rd_o,
   output logic              illegal_o
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic        rtypeOk;
   logic        unused_shamt;

   assign opcode       = instr_i[31:26];
   assign funct        = instr_i[5:0];
   assign imm          = instr_i[15:0];
   assign unused_shamt = ^instr_i[10:6];

   always_comb begin
      src1_o    = '0;
      src2_o    = '0;
      ctrl_o    = ALU_ADDU;
      rd_o      = '0;
      illegal_o = 1'b1;
      rtypeOk   = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_AND:  ctrl_o = ALU_AND;
               FN_OR:   ctrl_o = ALU_OR;
               FN_NOR:  ctrl_o = ALU_NOR;
               FN_ADDU: ctrl_o = ALU_ADDU;
               FN_SUBU: ctrl_o = ALU_SUBU;
               FN_SLT:  ctrl_o = ALU_SLT;
               default: rtypeOk = 1'b0;
            endcase
            if (rtypeOk) begin
               src1_o    = rs_data_i;
               src2_o    = rt_data_i;
               rd_o      = instr_i[15:11];
               illegal_o = 1'b0;
            end else begin
               ctrl_o = ALU_ADDU;
            end
         end
         OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
            src1_o    = rs_data_i;
            rd_o      = instr_i[20:16];
            illegal_o = 1'b0;
            case (opcode)
               OP_ADDIU: begin ctrl_o = ALU_ADDU; src2_o = sext16(imm); end
               OP_SLTI:  begin ctrl_o = ALU_SLT;  src2_o = sext16(imm); end
               OP_ANDI:  begin ctrl_o = ALU_AND;  src2_o = zext16(imm); end
               default:  begin ctrl_o = ALU_OR;   src2_o = zext16(imm); end
            endcase
         end
         OP_BEQ: begin
            src1_o    = rs_data_i;
            src2_o    = rt_data_i;
            ctrl_o    = ALU_EQUAL;
            illegal_o = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decoded ops held in an output register plus a one-entry
// skid register so in_ready_o comes straight from a flop.
module alu_issue
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       instr_i,
   input  logic [31:0]       rs_data_i,
   input  logic [31:0]       rt_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       src1_o,
   output logic [31:0]       src2_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [4:0]        rd_addr_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  issue_cnt_o
);

   issue_op_t        dec;
   issue_op_t        or_q, or_d;
   issue_op_t        sk_q, sk_d;
   logic             or_valid_q, or_valid_d;
   logic             sk_valid_q, sk_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_hs;
   logic             out_hs;

   alu_decode u_decode (
      .instr_i   (instr_i),
      .rs_data_i (rs_data_i),
      .rt_data_i (rt_data_i),
      .src1_o    (dec.src1),
      .src2_o    (dec.src2),
      .ctrl_o    (dec.ctrl),
      .rd_o      (dec.rd),
      .illegal_o (dec.illegal)
   );

   assign in_ready_o = !sk_valid_q;
   assign in_hs      = in_valid_i && in_ready_o;
   assign out_hs     = or_valid_q && out_ready_i;

   // The skid entry is always older than any new input, so it refills OR first;
   // a new input can only arrive while SK is empty.
   always_comb begin
      or_d       = or_q;
      sk_d       = sk_q;
      or_valid_d = or_valid_q;
      sk_valid_d = sk_valid_q;
      if (flush_i) begin
         or_valid_d = 1'b0;
         sk_valid_d = 1'b0;
      end else if (!or_valid_q || out_hs) begin
         if (sk_valid_q) begin
            or_d       = sk_q;
            or_valid_d = 1'b1;
            sk_valid_d = 1'b0;
         end else if (in_hs) begin
            or_d       = dec;
            or_valid_d = 1'b1;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (in_hs) begin
         sk_d       = dec;
         sk_valid_d = 1'b1;
      end
      cnt_d = (out_hs && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         or_q       <= '0;
         sk_q       <= '0;
         or_valid_q <= 1'b0;
         sk_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         or_q       <= or_d;
         sk_q       <= sk_d;
         or_valid_q <= or_valid_d;
         sk_valid_q <= sk_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid_o = or_valid_q;
   assign src1_o      = or_q.src1;
   assign src2_o      = or_q.src2;
   assign ctrl_o      = or_q.ctrl;
   assign rd_addr_o   = or_q.rd;
   assign illegal_o   = or_q.illegal;
   assign issue_cnt_o = cnt_q;

endmodule
